// File: rtl/branch_predict_resolve_if.sv
// ID-stage lookup and EX-stage resolution signals shared between the pipeline
// and the branch predictor/resolver.
interface branch_predict_resolve_if #(
  parameter int STAT_W = 16
) ();
  logic [31:0]       id_pc;
  logic              id_is_branch;
  logic [15:0]       id_imm;
  logic              pred_taken;
  logic [31:0]       pred_target;

  logic              ex_valid;
  logic              ex_is_branch;
  logic              ex_is_jump;
  logic [31:0]       ex_pc;
  logic              ex_pred_taken;
  logic              ex_taken;
  logic [31:0]       ex_target;
  logic [1:0]        Nexttype;
  logic [31:0]       redirect_pc;

  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispredict_cnt;

  // Pipeline side: drives instruction info, consumes predictions and redirects.
  modport master (
    output id_pc, id_is_branch, id_imm,
    output ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_pred_taken, ex_taken, ex_target,
    input  pred_taken, pred_target, Nexttype, redirect_pc, branch_cnt, mispredict_cnt
  );

  // Predictor side.
  modport slave (
    input  id_pc, id_is_branch, id_imm,
    input  ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_pred_taken, ex_taken, ex_target,
    output pred_taken, pred_target, Nexttype, redirect_pc, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_resolve.sv
// Two-bit saturating-counter BHT with ID-stage prediction and EX-stage
// resolution producing the Nexttype code and corrective PC.
module branch_predict_resolve #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         STAT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  branch_predict_resolve_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    NT_PCPLUS4      = 2'b00,
    NT_BRANCH       = 2'b01,
    NT_BRANCH_WRONG = 2'b10,
    NT_JUMP         = 2'b11
  } nexttype_e;

  logic [1:0]        bht_q [DEPTH];
  logic [1:0]        bht_entry_d;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
  nexttype_e         nexttype;
  logic [31:0]       ex_pc_plus4;
  logic [IDX_W-1:0]  id_idx, ex_idx;
  logic              update_en;

  assign id_idx      = bus.id_pc[IDX_W+1:2];
  assign ex_idx      = bus.ex_pc[IDX_W+1:2];
  assign ex_pc_plus4 = bus.ex_pc + 32'd4;
  assign update_en   = bus.ex_valid & bus.ex_is_branch & ~bus.ex_is_jump;

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign bus.pred_taken  = bus.id_is_branch & bht_q[id_idx][1];
  assign bus.pred_target = bus.id_pc + 32'd4 + {{14{bus.id_imm[15]}}, bus.id_imm, 2'b00};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    nexttype        = NT_PCPLUS4;
    bus.redirect_pc = ex_pc_plus4;
    if (!bus.ex_valid) begin
      nexttype = NT_PCPLUS4;
    end else if (bus.ex_is_jump) begin
      nexttype        = NT_JUMP;
      bus.redirect_pc = bus.ex_target;
    end else if (bus.ex_is_branch) begin
      if (bus.ex_taken == bus.ex_pred_taken) begin
        nexttype = NT_BRANCH;
      end else begin
        nexttype        = NT_BRANCH_WRONG;
        bus.redirect_pc = bus.ex_taken ? bus.ex_target : ex_pc_plus4;
      end
    end
  end

  assign bus.Nexttype = nexttype;

  always_comb begin
    bht_entry_d = bht_q[ex_idx];
    if (bus.ex_taken) begin
      if (bht_q[ex_idx] != 2'b11) bht_entry_d = bht_q[ex_idx] + 2'd1;
    end else begin
      if (bht_q[ex_idx] != 2'b00) bht_entry_d = bht_q[ex_idx] - 2'd1;
    end

    branch_cnt_d = branch_cnt_q;
    if (update_en && (branch_cnt_q != {STAT_W{1'b1}}))
      branch_cnt_d = branch_cnt_q + STAT_W'(1);

    mispredict_cnt_d = mispredict_cnt_q;
    if ((nexttype == NT_BRANCH_WRONG) && (mispredict_cnt_q != {STAT_W{1'b1}}))
      mispredict_cnt_d = mispredict_cnt_q + STAT_W'(1);
  end

  // NOTE: the table is a small flop array, so it can and must be reset to the weakly-not-taken state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= CNT_INIT;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (update_en) bht_q[ex_idx] <= bht_entry_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed-vector bench for branch_predict_resolve with a queue-based scoreboard:
// the driver pushes hand-computed expectations, a monitor pops and compares.
module tb_branch_predict_resolve;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   vec_no = 0;

  always #5 clk = ~clk;

  branch_predict_resolve_if #(.STAT_W(16)) bus ();

  branch_predict_resolve #(
    .IDX_W    (4),
    .CNT_INIT (2'b01),
    .STAT_W   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          id;
    logic        pred;
    logic [31:0] tgt;
    logic [1:0]  nt;
    logic [31:0] redir;
    logic [15:0] bcnt;
    logic [15:0] mcnt;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of ID/EX inputs and queue the expected response for that cycle.
  task automatic step(
    input logic [31:0] ipc, input logic ibr, input logic [15:0] imm,
    input logic ev, input logic eb, input logic ej, input logic [31:0] epc,
    input logic ept, input logic etk, input logic [31:0] etg,
    input logic xp, input logic [31:0] xtg, input logic [1:0] xnt,
    input logic [31:0] xrd, input logic [15:0] xb, input logic [15:0] xm);
    exp_t e;
    @(negedge clk);
    #1;
    bus.id_pc         = ipc;
    bus.id_is_branch  = ibr;
    bus.id_imm        = imm;
    bus.ex_valid      = ev;
    bus.ex_is_branch  = eb;
    bus.ex_is_jump    = ej;
    bus.ex_pc         = epc;
    bus.ex_pred_taken = ept;
    bus.ex_taken      = etk;
    bus.ex_target     = etg;
    vec_no++;
    e = '{vec_no, xp, xtg, xnt, xrd, xb, xm};
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("v%0d pred_taken", e.id),     32'(bus.pred_taken),     32'(e.pred));
        check($sformatf("v%0d pred_target", e.id),    bus.pred_target,         e.tgt);
        check($sformatf("v%0d Nexttype", e.id),       32'(bus.Nexttype),       32'(e.nt));
        check($sformatf("v%0d redirect_pc", e.id),    bus.redirect_pc,         e.redir);
        check($sformatf("v%0d branch_cnt", e.id),     32'(bus.branch_cnt),     32'(e.bcnt));
        check($sformatf("v%0d mispredict_cnt", e.id), 32'(bus.mispredict_cnt), 32'(e.mcnt));
      end
    end
  end

  task automatic drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #4;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : driver
    bus.id_pc = '0; bus.id_is_branch = 1'b0; bus.id_imm = '0;
    bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_is_jump = 1'b0;
    bus.ex_pc = '0; bus.ex_pred_taken = 1'b0; bus.ex_taken = 1'b0; bus.ex_target = '0;

    // Reset state observed while reset is held.
    #2;
    check("reset branch_cnt", 32'(bus.branch_cnt), 32'd0);
    check("reset mispredict_cnt", 32'(bus.mispredict_cnt), 32'd0);
    check("reset Nexttype", 32'(bus.Nexttype), 32'd0);
    check("reset redirect_pc", bus.redirect_pc, 32'h4);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //   id_pc       br imm       ev eb ej ex_pc      pt tk ex_tgt       | pred tgt           nt     redir        bcnt      mcnt
    step(32'h40,     1, 16'h0003, 0, 0, 0, 32'h0,     0, 0, 32'h0,        0, 32'h50,       2'b00, 32'h4,       16'd0,    16'd0);
    step(32'h40,     0, 16'h0003, 1, 1, 0, 32'h40,    0, 1, 32'h50,       0, 32'h50,       2'b10, 32'h50,      16'd0,    16'd0);
    step(32'h40,     1, 16'h0003, 1, 1, 0, 32'h40,    1, 1, 32'h50,       1, 32'h50,       2'b01, 32'h44,      16'd1,    16'd1);
    step(32'h40,     1, 16'h0003, 1, 1, 0, 32'h40,    1, 1, 32'h50,       1, 32'h50,       2'b01, 32'h44,      16'd2,    16'd1);
    step(32'h40,     1, 16'h0003, 1, 1, 0, 32'h40,    1, 1, 32'h50,       1, 32'h50,       2'b01, 32'h44,      16'd3,    16'd1);
    // Jump that is also flagged as a branch: Jump wins, no training.
    step(32'h40,     1, 16'h0003, 1, 1, 1, 32'h40,    1, 0, 32'h1000,     1, 32'h50,       2'b11, 32'h1000,    16'd4,    16'd1);
    // Bubble carrying stale branch bits, then a non-branch instruction.
    step(32'h40,     1, 16'h0003, 0, 1, 0, 32'h40,    1, 0, 32'h50,       1, 32'h50,       2'b00, 32'h44,      16'd4,    16'd1);
    step(32'h40,     1, 16'h0003, 1, 0, 0, 32'h100,   0, 0, 32'h0,        1, 32'h50,       2'b00, 32'h104,     16'd4,    16'd1);
    // Not-taken mispredicts walk BHT[0] 11 -> 10 -> 01; negative offsets in ID.
    step(32'h80,     1, 16'hFFFF, 1, 1, 0, 32'h40,    1, 0, 32'h50,       1, 32'h80,       2'b10, 32'h44,      16'd4,    16'd1);
    step(32'h44,     1, 16'h8000, 1, 1, 0, 32'h40,    1, 0, 32'h50,       0, 32'hFFFE0048, 2'b10, 32'h44,      16'd5,    16'd2);
    // Same-cycle lookup and update of index 0: old value (01) is seen.
    step(32'h80,     1, 16'h0000, 1, 1, 0, 32'h80,    0, 1, 32'h200,      0, 32'h84,       2'b10, 32'h200,     16'd6,    16'd3);
    step(32'h80,     1, 16'h0000, 0, 0, 0, 32'h80,    0, 0, 32'h0,        1, 32'h84,       2'b00, 32'h84,      16'd7,    16'd4);
    // Index 1: correct not-taken (01 -> 00), then taken mispredict (00 -> 01).
    step(32'h44,     1, 16'h0000, 1, 1, 0, 32'h44,    0, 0, 32'h300,      0, 32'h48,       2'b01, 32'h48,      16'd7,    16'd4);
    step(32'h44,     1, 16'h0000, 0, 0, 0, 32'h0,     0, 0, 32'h0,        0, 32'h48,       2'b00, 32'h4,       16'd8,    16'd4);
    step(32'h44,     1, 16'h0000, 1, 1, 0, 32'h44,    0, 1, 32'h300,      0, 32'h48,       2'b10, 32'h300,     16'd8,    16'd4);
    step(32'h44,     1, 16'h0000, 0, 0, 0, 32'h0,     0, 0, 32'h0,        0, 32'h48,       2'b00, 32'h4,       16'd9,    16'd5);
    // Non-branch in ID never predicts taken even though BHT[0] is 10.
    step(32'h40,     0, 16'h0000, 0, 0, 0, 32'h0,     0, 0, 32'h0,        0, 32'h44,       2'b00, 32'h4,       16'd9,    16'd5);

    // Fill branch_cnt from 9 up to all-ones with correctly predicted branches.
    @(negedge clk);
    #1;
    bus.id_pc = '0; bus.id_is_branch = 1'b0; bus.id_imm = '0;
    bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_is_jump = 1'b0;
    bus.ex_pc = 32'h40; bus.ex_pred_taken = 1'b1; bus.ex_taken = 1'b1; bus.ex_target = 32'h50;
    repeat (65526) @(posedge clk);

    step(32'h0,      0, 16'h0000, 1, 1, 0, 32'h40,    1, 1, 32'h50,       0, 32'h4,        2'b01, 32'h44,      16'hFFFF, 16'd5);
    step(32'h0,      0, 16'h0000, 1, 1, 0, 32'h40,    1, 1, 32'h50,       0, 32'h4,        2'b01, 32'h44,      16'hFFFF, 16'd5);
    drain();

    // Mid-cycle reset: counters clear at once and every entry reads not-taken.
    bus.ex_valid = 1'b0; bus.id_is_branch = 1'b1; bus.id_imm = '0;
    rst = 1'b1;
    #1;
    check("midreset branch_cnt", 32'(bus.branch_cnt), 32'd0);
    check("midreset mispredict_cnt", 32'(bus.mispredict_cnt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.id_pc = 32'(i) << 2;
      #1;
      check($sformatf("midreset pred_taken idx%0d", i), 32'(bus.pred_taken), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // One taken update proves the reset value was 01 (01 -> 10 predicts taken).
    step(32'h0,      0, 16'h0000, 1, 1, 0, 32'h54,    0, 1, 32'h60,       0, 32'h4,        2'b10, 32'h60,      16'd0,    16'd0);
    step(32'h54,     1, 16'h0000, 0, 0, 0, 32'h0,     0, 0, 32'h0,        1, 32'h58,       2'b00, 32'h4,       16'd1,    16'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Two-bit saturating-counter branch history table (BHT) plus EX-stage branch resolution logic.
- In ID it looks up a taken/not-taken prediction and computes the predicted target for the instruction being decoded.
- In EX it compares the actual outcome with the prediction carried down the pipe and produces the 2-bit Nexttype code consumed by the hazard detection unit. It also produces the corrective PC.
- It trains the BHT on every resolved branch and keeps saturating branch/mispredict statistics counters.

Parameters:
- IDX_W, 4, BHT index width; table depth = 2**IDX_W entries.
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_pc  in  32  PC of the instruction in ID.
- id_is_branch  in  1  ID instruction is a conditional branch (beq/bne).
- id_imm  in  16  branch offset field of the ID instruction.
- pred_taken  out  1  prediction for the ID instruction.
- pred_target  out  32  id_pc + 4 + (sign-extended id_imm << 2).
- ex_valid  in  1  EX stage holds a real instruction, not a bubble.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_is_jump  in  1  EX instruction is j/jal/jr.
- ex_pc  in  32  PC of the EX instruction.
- ex_pred_taken  in  1  pred_taken value carried through ID/EX.
- ex_taken  in  1  actual branch outcome from the ALU compare.
- ex_target  in  32  computed branch or jump target.
- Nexttype  out  2  00 PCPlus4, 01 Branch, 10 BranchWrong, 11 Jump.
- redirect_pc  out  32  correct next PC when Nexttype is BranchWrong or Jump.
- branch_cnt  out  STAT_W  resolved conditional branches.
- mispredict_cnt  out  STAT_W  BranchWrong occurrences.

Behaviour:
- Reset (asynchronous, immediate):
  - every BHT entry = CNT_INIT;
  - branch_cnt = 0 and mispredict_cnt = 0.
  - Combinational outputs follow their inputs; with ex_valid=0, Nexttype=00 and redirect_pc=ex_pc+4.
- Index: id_pc[IDX_W+1:2] for lookup, ex_pc[IDX_W+1:2] for update. Upper PC bits are ignored, so aliasing is permitted.
- Lookup (combinational): pred_taken = id_is_branch & BHT[idx][1]. pred_taken is 0 when id_is_branch=0.
- Resolution (combinational, priority order):
  1. ex_valid=0 → Nexttype 00.
  2. ex_is_jump=1 → Nexttype 11, redirect_pc = ex_target. This applies even if ex_is_branch is also 1.
  3. ex_is_branch=1 and ex_taken==ex_pred_taken → Nexttype 01, redirect_pc = ex_pc+4 (unused).
  4. ex_is_branch=1 and ex_taken!=ex_pred_taken → Nexttype 10. redirect_pc = ex_target if ex_taken, else ex_pc+4.
  5. Otherwise → Nexttype 00.
- BHT update (posedge clk): only when ex_valid & ex_is_branch & ~ex_is_jump.
  - ex_taken=1: counter increments, saturating at 11.
  - ex_taken=0: counter decrements, saturating at 00.
  - Jumps and bubbles never modify the table.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update (old) value. There is no bypass.
- Statistics (posedge clk):
  - branch_cnt increments on each update event.
  - mispredict_cnt increments when Nexttype==10.
  - Both saturate at all-ones and never wrap.
- Stalls: a load stall inserts a bubble into ID/EX (ex_valid=0), so no instruction is trained twice. The block has no stall input.
- Reset asserted mid-operation: the table and counters clear immediately. Any in-flight ex_pred_taken then reflects the old table; resolution remains correct because it compares against the carried bit.

Test Plan:
- Reset, then ID branch at id_pc=0x40, id_imm=0x0003 → pred_taken=0, pred_target=0x50.
- EX branch at ex_pc=0x40, ex_pred_taken=0, ex_taken=1, ex_target=0x50 → Nexttype=10, redirect_pc=0x50. Next cycle: BHT[0]=10, branch_cnt=1, mispredict_cnt=1. ID lookup of 0x40 then gives pred_taken=1.
- Three further taken resolutions at 0x40 with ex_pred_taken=1 → Nexttype=01 each time; BHT[0] saturates at 11 and holds; mispredict_cnt stays 1.
- ex_is_jump=1 and ex_is_branch=1 with ex_target=0x1000 → Nexttype=11, redirect_pc=0x1000, no BHT change, branch_cnt unchanged.
- Same-cycle ID lookup at 0x80 and EX update at 0x80 (IDX_W=4 → idx 0) with the counter at 01 → pred_taken=0 that cycle; counter becomes 10 after the edge.
- Force branch_cnt to 0xFFFF, then resolve one more branch → stays 0xFFFF. Assert rst mid-cycle → all counters read 0 and all BHT entries read 01 before the next edge.
